// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the fetch queue and decode.
// The fetch/decode side uses master; the queue itself uses slave.
interface fetch_queue_if #(
   parameter int XLEN  = 64,
   parameter int ILEN  = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);

   logic            push_valid_F;
   logic            push_ready_F;
   logic [XLEN-1:0] PC_F;
   logic [ILEN-1:0] Instr_F;
   logic            pop_ready_D;
   logic            valid_D;
   logic [XLEN-1:0] PC_D;
   logic [ILEN-1:0] Instr_D;
   logic            flush;
   logic [CW-1:0]   count;

   modport master (
      output push_valid_F, PC_F, Instr_F, pop_ready_D, flush,
      input  push_ready_F, valid_D, PC_D, Instr_D, count
   );

   modport slave (
      input  push_valid_F, PC_F, Instr_F, pop_ready_D, flush,
      output push_ready_F, valid_D, PC_D, Instr_D, count
   );
endinterface

// File: rtl/fetch_queue.sv
// FIFO of {PC, Instr} pairs between fetch and decode, with flush on redirect.
// An optional bypass lets a push into an empty queue reach decode in the same cycle.
module fetch_queue #(
   parameter int XLEN   = 64,
   parameter int ILEN   = 32,
   parameter int DEPTH  = 4,
   parameter int BYPASS = 0
) (
   input logic         clk,
   input logic         rst,
   fetch_queue_if.slave q
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]   FULL_C  = CW'(DEPTH);
   localparam logic [CW-1:0]   CNT_ONE = CW'(1);
   localparam logic [PW-1:0]   PTR_ONE = PW'(1);
   localparam logic [ILEN-1:0] NOP     = ILEN'(32'h0000_0013);

   logic [XLEN-1:0] mem_pc    [DEPTH];
   logic [ILEN-1:0] mem_instr [DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [CW-1:0]   cnt;

   logic empty, full, bypass_hit, bypass_take;
   logic push_fire, pop_fire, do_write, do_read;

   assign empty = (cnt == '0);
   assign full  = (cnt == FULL_C);

   // Bypass only applies to an empty queue; once anything is stored, order comes from memory.
   assign bypass_hit  = (BYPASS != 0) && empty && q.push_valid_F && !q.flush;
   assign bypass_take = bypass_hit && q.pop_ready_D;

   assign q.push_ready_F = !full && !q.flush;
   assign q.valid_D      = !q.flush && (!empty || bypass_hit);
   assign q.count        = cnt;

   assign push_fire = q.push_valid_F && q.push_ready_F;
   assign pop_fire  = q.valid_D && q.pop_ready_D;
   assign do_write  = push_fire && !bypass_take;
   assign do_read   = pop_fire && !bypass_take;

   always_comb begin
      q.PC_D    = '0;
      q.Instr_D = NOP;
      if (bypass_hit) begin
         q.PC_D    = q.PC_F;
         q.Instr_D = q.Instr_F;
      end else if (!empty) begin
         q.PC_D    = mem_pc[rd_ptr];
         q.Instr_D = mem_instr[rd_ptr];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || q.flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_read)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_write, do_read})
            2'b10:   cnt <= cnt + CNT_ONE;
            2'b01:   cnt <= cnt - CNT_ONE;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage is deliberately left unreset; empty-queue outputs are forced above instead.
   always_ff @(posedge clk) begin
      if (!rst && do_write) begin
         mem_pc[wr_ptr]    <= q.PC_F;
         mem_instr[wr_ptr] <= q.Instr_F;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: one instance without bypass, one with bypass.
module tb_fetch_queue;
   localparam int XLEN  = 64;
   localparam int ILEN  = 32;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);
   localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   int   mcount = 0;
   logic [XLEN-1:0] sb [$];

   fetch_queue_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) qa ();
   fetch_queue_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) qb ();

   fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .BYPASS(0)) dut_a (.clk(clk), .rst(rst), .q(qa));
   fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .BYPASS(1)) dut_b (.clk(clk), .rst(rst), .q(qb));

   always #5 clk = ~clk;

   function automatic logic [ILEN-1:0] instr_of(input logic [XLEN-1:0] pc);
      return pc[31:0] ^ 32'hC0DE_0000;
   endfunction

   task automatic driveA(input logic pv, input logic [XLEN-1:0] pc, input logic pr, input logic fl);
      qa.push_valid_F = pv;
      qa.PC_F         = pc;
      qa.Instr_F      = instr_of(pc);
      qa.pop_ready_D  = pr;
      qa.flush        = fl;
      #1;
   endtask

   task automatic driveB(input logic pv, input logic [XLEN-1:0] pc, input logic pr);
      qb.push_valid_F = pv;
      qb.PC_F         = pc;
      qb.Instr_F      = instr_of(pc);
      qb.pop_ready_D  = pr;
      qb.flush        = 1'b0;
      #1;
   endtask

   task automatic nextCycle;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      driveA(1'b1, 64'h1000, 1'b0, 1'b0);
      driveB(1'b0, 64'h0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      checks++; if (qa.count !== CW'(0)) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", qa.count); end
      checks++; if (qa.valid_D !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", qa.valid_D); end
      checks++; if (qa.Instr_D !== NOP) begin errors++; $display("[TB] FAIL reset_instr: got %h expected %h", qa.Instr_D, NOP); end
      checks++; if (qa.PC_D !== 64'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", qa.PC_D); end
      checks++; if (qa.push_ready_F !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", qa.push_ready_F); end
      checks++; if (qb.count !== CW'(0)) begin errors++; $display("[TB] FAIL reset_count_b: got %0d expected 0", qb.count); end
      rst = 1'b0;
      driveA(1'b0, 64'h0, 1'b0, 1'b0);
      mcount = 0;
      sb.delete();
   endtask

   task automatic test_fill_full;
      logic [XLEN-1:0] exp;
      logic            acc;
      int              guard;
      for (int k = 0; k < 5; k++) begin
         nextCycle;
         driveA(1'b1, XLEN'(4 * k), 1'b0, 1'b0);
         acc = (mcount != DEPTH);
         checks++; if (qa.push_ready_F !== acc) begin errors++; $display("[TB] FAIL fill_ready[%0d]: got %b expected %b", k, qa.push_ready_F, acc); end
         checks++; if (qa.valid_D !== (mcount != 0)) begin errors++; $display("[TB] FAIL fill_valid[%0d]: got %b expected %b", k, qa.valid_D, mcount != 0); end
         if (k > 0) begin
            checks++; if (qa.PC_D !== 64'h0) begin errors++; $display("[TB] FAIL stall_head[%0d]: got %h expected 0", k, qa.PC_D); end
         end
         if (acc) begin sb.push_back(XLEN'(4 * k)); mcount++; end
      end
      nextCycle;
      driveA(1'b0, 64'h0, 1'b0, 1'b0);
      checks++; if (qa.count !== CW'(4)) begin errors++; $display("[TB] FAIL full_count: got %0d expected 4", qa.count); end
      checks++; if (qa.push_ready_F !== 1'b0) begin errors++; $display("[TB] FAIL full_ready: got %b expected 0", qa.push_ready_F); end
      guard = 0;
      while (sb.size() != 0 && guard < 10) begin
         driveA(guard == 0, 64'h10, 1'b1, 1'b0);
         acc = (guard == 0) && (mcount != DEPTH);
         checks++; if (qa.push_ready_F !== (mcount != DEPTH)) begin errors++; $display("[TB] FAIL drain_ready: got %b expected %b", qa.push_ready_F, mcount != DEPTH); end
         checks++; if (qa.valid_D !== 1'b1) begin errors++; $display("[TB] FAIL drain_valid: got %b expected 1", qa.valid_D); end
         exp = sb.pop_front();
         mcount--;
         checks++; if (qa.PC_D !== exp) begin errors++; $display("[TB] FAIL drain_pc: got %h expected %h", qa.PC_D, exp); end
         checks++; if (qa.Instr_D !== instr_of(exp)) begin errors++; $display("[TB] FAIL drain_instr: got %h expected %h", qa.Instr_D, instr_of(exp)); end
         if (acc) begin sb.push_back(64'h10); mcount++; end
         nextCycle;
         guard++;
      end
      checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL drain_timeout: got %0d left expected 0", sb.size()); end
      driveA(1'b0, 64'h0, 1'b0, 1'b0);
      checks++; if (qa.valid_D !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty_valid: got %b expected 0", qa.valid_D); end
      checks++; if (qa.count !== CW'(0)) begin errors++; $display("[TB] FAIL drain_empty_count: got %0d expected 0", qa.count); end
      sb.delete();
      mcount = 0;
   endtask

   task automatic test_wrap;
      logic [XLEN-1:0] exp;
      logic            pv, pr, acc, pop;
      int              next, popped, guard;
      next = 0; popped = 0; guard = 0;
      while ((next < 11 || sb.size() != 0) && guard < 200) begin
         pv = (next < 11);
         pr = ($urandom_range(0, 2) != 0);
         driveA(pv, 64'h100 + XLEN'(4 * next), pr, 1'b0);
         checks++; if (qa.count !== CW'(mcount) || qa.count > CW'(DEPTH)) begin errors++; $display("[TB] FAIL wrap_count: got %0d expected %0d", qa.count, mcount); end
         checks++; if (qa.push_ready_F !== (mcount != DEPTH)) begin errors++; $display("[TB] FAIL wrap_ready: got %b expected %b", qa.push_ready_F, mcount != DEPTH); end
         checks++; if (qa.valid_D !== (mcount != 0)) begin errors++; $display("[TB] FAIL wrap_valid: got %b expected %b", qa.valid_D, mcount != 0); end
         acc = pv && (mcount != DEPTH);
         pop = (mcount != 0) && pr;
         if (pop) begin
            exp = sb.pop_front();
            popped++;
            checks++; if (qa.PC_D !== exp) begin errors++; $display("[TB] FAIL wrap_pc: got %h expected %h", qa.PC_D, exp); end
         end
         if (acc) begin sb.push_back(64'h100 + XLEN'(4 * next)); next++; end
         mcount = mcount + (acc ? 1 : 0) - (pop ? 1 : 0);
         nextCycle;
         guard++;
      end
      checks++; if (guard >= 200 || popped != 11) begin errors++; $display("[TB] FAIL wrap_timeout: got %0d popped expected 11", popped); end
      driveA(1'b0, 64'h0, 1'b0, 1'b0);
      sb.delete();
      mcount = 0;
   endtask

   task automatic test_back_to_back;
      logic [XLEN-1:0] exp;
      driveA(1'b1, 64'h500, 1'b0, 1'b0); sb.push_back(64'h500);
      nextCycle;
      driveA(1'b1, 64'h504, 1'b0, 1'b0); sb.push_back(64'h504);
      nextCycle;
      driveA(1'b1, 64'h508, 1'b1, 1'b0);
      checks++; if (qa.count !== CW'(2)) begin errors++; $display("[TB] FAIL b2b_count_before: got %0d expected 2", qa.count); end
      exp = sb.pop_front();
      checks++; if (qa.PC_D !== exp) begin errors++; $display("[TB] FAIL b2b_head0: got %h expected %h", qa.PC_D, exp); end
      sb.push_back(64'h508);
      nextCycle;
      driveA(1'b0, 64'h0, 1'b1, 1'b0);
      checks++; if (qa.count !== CW'(2)) begin errors++; $display("[TB] FAIL b2b_count_after: got %0d expected 2", qa.count); end
      exp = sb.pop_front();
      checks++; if (qa.PC_D !== exp) begin errors++; $display("[TB] FAIL b2b_head1: got %h expected %h", qa.PC_D, exp); end
      nextCycle;
      driveA(1'b0, 64'h0, 1'b1, 1'b0);
      exp = sb.pop_front();
      checks++; if (qa.PC_D !== exp) begin errors++; $display("[TB] FAIL b2b_head2: got %h expected %h", qa.PC_D, exp); end
      nextCycle;
      driveA(1'b0, 64'h0, 1'b0, 1'b0);
      checks++; if (qa.valid_D !== 1'b0 || qa.count !== CW'(0)) begin errors++; $display("[TB] FAIL b2b_empty: got valid=%b count=%0d expected 0/0", qa.valid_D, qa.count); end
   endtask

   task automatic test_flush;
      logic [XLEN-1:0] exp;
      driveA(1'b1, 64'h600, 1'b0, 1'b0); nextCycle;
      driveA(1'b1, 64'h604, 1'b0, 1'b0); nextCycle;
      driveA(1'b1, 64'h608, 1'b0, 1'b0); nextCycle;
      driveA(1'b1, 64'h200, 1'b1, 1'b1);
      checks++; if (qa.count !== CW'(3)) begin errors++; $display("[TB] FAIL flush_count_before: got %0d expected 3", qa.count); end
      checks++; if (qa.valid_D !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid: got %b expected 0", qa.valid_D); end
      checks++; if (qa.push_ready_F !== 1'b0) begin errors++; $display("[TB] FAIL flush_ready: got %b expected 0", qa.push_ready_F); end
      nextCycle;
      driveA(1'b1, 64'h300, 1'b0, 1'b0);
      sb.push_back(64'h300);
      checks++; if (qa.count !== CW'(0)) begin errors++; $display("[TB] FAIL flush_count_after: got %0d expected 0", qa.count); end
      checks++; if (qa.valid_D !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid_after: got %b expected 0", qa.valid_D); end
      nextCycle;
      driveA(1'b0, 64'h0, 1'b1, 1'b0);
      checks++; if (qa.count !== CW'(1) || qa.valid_D !== 1'b1) begin errors++; $display("[TB] FAIL flush_kept: got count=%0d valid=%b expected 1/1", qa.count, qa.valid_D); end
      exp = sb.pop_front();
      checks++; if (qa.PC_D !== exp) begin errors++; $display("[TB] FAIL flush_head: got %h expected %h", qa.PC_D, exp); end
      nextCycle;
      driveA(1'b0, 64'h0, 1'b0, 1'b0);
      checks++; if (qa.valid_D !== 1'b0 || qa.count !== CW'(0)) begin errors++; $display("[TB] FAIL flush_drop: got valid=%b count=%0d expected 0/0", qa.valid_D, qa.count); end
   endtask

   task automatic test_bypass;
      logic [XLEN-1:0] exp;
      driveB(1'b1, 64'h40, 1'b1);
      sb.push_back(64'h40);
      checks++; if (qb.valid_D !== 1'b1) begin errors++; $display("[TB] FAIL byp_valid: got %b expected 1", qb.valid_D); end
      exp = sb.pop_front();
      checks++; if (qb.PC_D !== exp) begin errors++; $display("[TB] FAIL byp_pc: got %h expected %h", qb.PC_D, exp); end
      checks++; if (qb.Instr_D !== instr_of(exp)) begin errors++; $display("[TB] FAIL byp_instr: got %h expected %h", qb.Instr_D, instr_of(exp)); end
      nextCycle;
      driveB(1'b0, 64'h0, 1'b0);
      checks++; if (qb.count !== CW'(0) || qb.valid_D !== 1'b0) begin errors++; $display("[TB] FAIL byp_consumed: got count=%0d valid=%b expected 0/0", qb.count, qb.valid_D); end
      driveB(1'b1, 64'h44, 1'b0);
      sb.push_back(64'h44);
      checks++; if (qb.valid_D !== 1'b1 || qb.PC_D !== sb[0]) begin errors++; $display("[TB] FAIL byp_stall_now: got valid=%b pc=%h expected 1/%h", qb.valid_D, qb.PC_D, sb[0]); end
      nextCycle;
      driveB(1'b0, 64'h0, 1'b0);
      checks++; if (qb.count !== CW'(1)) begin errors++; $display("[TB] FAIL byp_stored_count: got %0d expected 1", qb.count); end
      checks++; if (qb.valid_D !== 1'b1 || qb.PC_D !== sb[0]) begin errors++; $display("[TB] FAIL byp_stored_head: got valid=%b pc=%h expected 1/%h", qb.valid_D, qb.PC_D, sb[0]); end
      driveB(1'b0, 64'h0, 1'b1);
      exp = sb.pop_front();
      nextCycle;
      driveB(1'b0, 64'h0, 1'b0);
      checks++; if (qb.count !== CW'(0) || qb.valid_D !== 1'b0) begin errors++; $display("[TB] FAIL byp_drained: got count=%0d valid=%b expected 0/0 after %h", qb.count, qb.valid_D, exp); end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      test_reset;
      test_fill_full;
      test_wrap;
      test_back_to_back;
      test_flush;
      test_bypass;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
